pc_next_reg: RTL and testbench

//  Next-PC selection plus PC register for the fetch stage; successor to the 1-bit PC source select.

---
 rtl/pc_next_reg.sv | 124 ++++++++++++
 tb/tb_pc_next_reg.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pc_next_reg.sv
// pc_next_reg: next-PC selection and PC register for the fetch stage.
//   Selects PC+4, the branch/JAL target or the JALR target. Holds the PC while
//   stalled, and keeps one redirect that arrives during a stall so it is applied
//   on the first unstalled edge. Also keeps a saturating count of applied redirects.
// Optional feature (macro PC_MISALIGN_CHK_EN): a target applied with [1:0]!=00
//   loads TRAP_VEC instead and pulses misalign for one cycle.
// Ports:
//   clk, rst    clock (rising edge), async active-high reset
//   stall       hold the PC this cycle
//   PCSrc       00 PC+4, 01 PCTarget, 10 ALUResult (JALR), 11 same as 00
//   PCTarget    branch/JAL target
//   ALUResult   JALR target (bit 0 forced to 0)
//   PC          current PC (registered)
//   PCPlus4     PC + 4, combinational, wraps
//   redirPend   a buffered redirect is waiting for stall release
//   redirCount  applied redirects, saturating at all-ones
//   misalign    one-cycle trap pulse (tied 0 when the macro is undefined)
module pc_next_reg #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] TRAP_VEC = 32'h0000_0100,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [1:0]            PCSrc,
    input  logic [DATA_WIDTH-1:0] PCTarget,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    output logic [DATA_WIDTH-1:0] PC,
    output logic [DATA_WIDTH-1:0] PCPlus4,
    output logic                  redirPend,
    output logic [CNT_WIDTH-1:0]  redirCount,
    output logic                  misalign
);

    logic                  redirect;
    logic [DATA_WIDTH-1:0] tgt;
    logic [DATA_WIDTH-1:0] pend_tgt;
    logic                  apply;
    logic [DATA_WIDTH-1:0] apply_tgt;
    logic [DATA_WIDTH-1:0] pc_next;
    logic                  trap;

    assign PCPlus4 = PC + DATA_WIDTH'(4);

    // Redirect decode; PCSrc=11 falls through as sequential.
    always_comb begin
        redirect  = 1'b0;
        tgt       = PCTarget;
        apply     = 1'b0;
        apply_tgt = pend_tgt;
        trap      = 1'b0;
        pc_next   = PCPlus4;

        redirect = (PCSrc == 2'b01) || (PCSrc == 2'b10);
        if (PCSrc == 2'b10) begin
            tgt = {ALUResult[DATA_WIDTH-1:1], 1'b0};
        end

        // A live redirect takes priority over one buffered during the stall.
        apply = !stall && (redirect || redirPend);
        if (redirect) begin
            apply_tgt = tgt;
        end

`ifdef PC_MISALIGN_CHK_EN
        // Alignment is judged on the target actually being applied.
        trap = apply && (apply_tgt[1:0] != 2'b00);
`endif

        if (stall) begin
            pc_next = PC;
        end else if (trap) begin
            pc_next = TRAP_VEC;
        end else if (apply) begin
            pc_next = apply_tgt;
        end
    end

    // PC, pending-redirect buffer and redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PC         <= RESET_PC;
            redirPend  <= 1'b0;
            pend_tgt   <= '0;
            redirCount <= '0;
        end else begin
            PC <= pc_next;
            if (stall) begin
                // Newest redirect seen during the stall overwrites an older one.
                if (redirect) begin
                    redirPend <= 1'b1;
                    pend_tgt  <= tgt;
                end
            end else begin
                redirPend <= 1'b0;
            end
            if (apply && (redirCount != {CNT_WIDTH{1'b1}})) begin
                redirCount <= redirCount + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    // Trap pulse is visible for the cycle after the trapping edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= trap;
        end
    end

    logic unused_alu_b0;
    assign unused_alu_b0 = ALUResult[0] ^ trap;
`else
    assign misalign = 1'b0;

    logic unused_cfg;
    assign unused_cfg = (^TRAP_VEC) ^ ALUResult[0] ^ trap;
`endif

endmodule

// File: tb/tb_pc_next_reg.sv
// Directed bench for pc_next_reg: sequential fetch, redirects, stall buffering,
// wrap-around, counter saturation (second instance, CNT_WIDTH=2) and async reset.
module tb_pc_next_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic [31:0] PC, PCPlus4, PC_s, PCPlus4_s;
    logic        redirPend, redirPend_s, misalign, misalign_s;
    logic [15:0] redirCount;
    logic [1:0]  redirCount_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_next_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc),
        .PCTarget(PCTarget), .ALUResult(ALUResult),
        .PC(PC), .PCPlus4(PCPlus4), .redirPend(redirPend),
        .redirCount(redirCount), .misalign(misalign)
    );

    pc_next_reg #(.CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .PCSrc(PCSrc),
        .PCTarget(PCTarget), .ALUResult(ALUResult),
        .PC(PC_s), .PCPlus4(PCPlus4_s), .redirPend(redirPend_s),
        .redirCount(redirCount_s), .misalign(misalign_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; PCSrc = 2'b00; PCTarget = '0; ALUResult = '0;
        #12;
        check("reset_pc", PC, 32'h0);
        check("reset_pend", 32'(redirPend), 32'h0);
        check("reset_cnt", 32'(redirCount), 32'h0);
        check("reset_misalign", 32'(misalign), 32'h0);
        check("reset_sat_cnt", 32'(redirCount_s), 32'h0);
        @(negedge clk); rst = 1'b0;

        // 1: sequential
        step(); check("seq_pc4", PC, 32'h4);
        step(); check("seq_pc8", PC, 32'h8);
        step(); check("seq_pcC", PC, 32'hC);
        check("seq_cnt", 32'(redirCount), 32'h0);
        step(); check("seq_pc10", PC, 32'h10);

        // 2: branch/JAL target
        PCSrc = 2'b01; PCTarget = 32'h200;
        step(); check("br_pc", PC, 32'h200);
        check("br_pcplus4", PCPlus4, 32'h204);
        check("br_cnt", 32'(redirCount), 32'h1);
        check("br_sat_cnt", 32'(redirCount_s), 32'h1);

        // 3: JALR, bit 0 cleared
        PCSrc = 2'b10; ALUResult = 32'h301;
        step(); check("jalr_pc", PC, 32'h300);
        check("jalr_cnt", 32'(redirCount), 32'h2);
        ALUResult = 32'h302;
        step();
`ifdef PC_MISALIGN_CHK_EN
        check("jalr_mis_pc", PC, 32'h100);
        check("jalr_mis_pulse", 32'(misalign), 32'h1);
`else
        check("jalr_mis_pc", PC, 32'h302);
        check("jalr_mis_pulse", 32'(misalign), 32'h0);
`endif
        check("jalr_mis_cnt", 32'(redirCount), 32'h3);
        PCSrc = 2'b11;
        step();
`ifdef PC_MISALIGN_CHK_EN
        check("rsvd_pc", PC, 32'h104);
`else
        check("rsvd_pc", PC, 32'h306);
`endif
        check("mis_pulse_end", 32'(misalign), 32'h0);
        check("rsvd_cnt", 32'(redirCount), 32'h3);

        // 4: redirect buffered during a stall
        PCSrc = 2'b01; PCTarget = 32'h400; stall = 1'b1;
        step();
`ifdef PC_MISALIGN_CHK_EN
        check("stall_hold1", PC, 32'h104);
`else
        check("stall_hold1", PC, 32'h306);
`endif
        check("stall_pend1", 32'(redirPend), 32'h1);
        PCSrc = 2'b00;
        step();
        check("stall_pend2", 32'(redirPend), 32'h1);
        check("stall_cnt", 32'(redirCount), 32'h3);
        stall = 1'b0;
        step(); check("release_pc", PC, 32'h400);
        check("release_pend", 32'(redirPend), 32'h0);
        check("release_cnt", 32'(redirCount), 32'h4);

        // 5: live redirect beats pending one
        stall = 1'b1; PCSrc = 2'b01; PCTarget = 32'h400;
        step(); check("pend_again", 32'(redirPend), 32'h1);
        stall = 1'b0; PCTarget = 32'h500;
        step(); check("live_wins_pc", PC, 32'h500);
        check("live_wins_pend", 32'(redirPend), 32'h0);
        check("live_wins_cnt", 32'(redirCount), 32'h5);
        PCSrc = 2'b00;
        step(); check("after_live_pc", PC, 32'h504);

        // Wrap-around and counter saturation
        PCSrc = 2'b01; PCTarget = 32'hFFFF_FFFC;
        step(); check("wrap_pcplus4", PCPlus4, 32'h0);
        check("sat_cnt", 32'(redirCount_s), 32'h3);
        check("wide_cnt", 32'(redirCount), 32'h6);
        PCSrc = 2'b00;
        step(); check("wrap_pc", PC, 32'h0);

        // 6: async reset while a redirect is pending
        stall = 1'b1; PCSrc = 2'b01; PCTarget = 32'h600;
        step(); check("pre_rst_pend", 32'(redirPend), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", PC, 32'h0);
        check("async_rst_pend", 32'(redirPend), 32'h0);
        check("async_rst_cnt", 32'(redirCount), 32'h0);
        PCSrc = 2'b00; stall = 1'b0;
        @(negedge clk); rst = 1'b0;
        step(); check("post_rst_pc", PC, 32'h4);
        check("post_rst_pend", 32'(redirPend), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
